// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes and baud derivation.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle   = 3'd0;
  localparam uart_state_t StStart  = 3'd1;
  localparam uart_state_t StData   = 3'd2;
  localparam uart_state_t StParity = 3'd3;
  localparam uart_state_t StStop   = 3'd4;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Clocks per bit; the receiver derives its bit period the same way.
  function automatic int unsigned uart_ticks(input int unsigned clock_hz,
                                             input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..TICKS-1 while enabled and strobes on the last count.
module uart_baud_counter #(
  parameter int unsigned TICKS = 86
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable_i,
  input  logic Clear_i,
  output logic Tick_o
);

  localparam int unsigned CW = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LastCount = CW'(TICKS - 1);

  logic [CW-1:0] count_q, count_d;

  assign Tick_o = Enable_i && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (Clear_i) begin
      count_d = '0;
    end else if (Enable_i) begin
      count_d = (count_q == LastCount) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first framing with optional parity and one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ  = 10_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_i,
  input  logic [7:0] Data_i,
  output logic       Tx_o,
  output logic       Busy_o,
  output logic       Done_o
);

  localparam int unsigned TICKS = uart_ticks(CLOCK_HZ, BAUD);
  localparam logic ParityEn  = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam logic ParityOdd = (PARITY == PARITY_ODD);
  localparam logic [2:0] StopLast = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        clear;
  logic        tick;

  uart_baud_counter #(
    .TICKS (TICKS)
  ) u_baud (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable_i (busy_q),
    .Clear_i  (clear),
    .Tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clear     = 1'b0;

    case (state_q)
      StIdle: begin
        if (Start_i) begin
          shift_d   = Data_i;
          parity_d  = (^Data_i) ^ ParityOdd;
          bit_cnt_d = 3'd0;
          busy_d    = 1'b1;
          clear     = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = ParityEn ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        // bit_cnt_q doubles as the stop-bit index here.
        if (tick) begin
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = 3'd0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Line level follows the next state so the start bit appears on the accepting edge.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Tx_o   = tx_q;
  assign Busy_o = busy_q;
  assign Done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations checked cycle-by-cycle against bit tables.
module tb_uart_tx;

  localparam int T = 86;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start = '0;
  logic [7:0] data [4];
  wire  [3:0] tx_w, busy_w, done_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) u_def (
    .Clock(clk), .Reset(rst), .Start_i(start[0]), .Data_i(data[0]),
    .Tx_o(tx_w[0]), .Busy_o(busy_w[0]), .Done_o(done_w[0]));
  uart_tx #(.PARITY(2), .STOP_BITS(1)) u_even (
    .Clock(clk), .Reset(rst), .Start_i(start[1]), .Data_i(data[1]),
    .Tx_o(tx_w[1]), .Busy_o(busy_w[1]), .Done_o(done_w[1]));
  uart_tx #(.PARITY(1), .STOP_BITS(1)) u_odd (
    .Clock(clk), .Reset(rst), .Start_i(start[2]), .Data_i(data[2]),
    .Tx_o(tx_w[2]), .Busy_o(busy_w[2]), .Done_o(done_w[2]));
  uart_tx #(.PARITY(0), .STOP_BITS(2)) u_stop2 (
    .Clock(clk), .Reset(rst), .Start_i(start[3]), .Data_i(data[3]),
    .Tx_o(tx_w[3]), .Busy_o(busy_w[3]), .Done_o(done_w[3]));

  // bits[i] is the line level of frame bit i (bit 0 = start bit).
  typedef struct {
    int         dut;
    logic [7:0] data;
    int         nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {tx,busy,done}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and returns 1 ns after the accepting edge.
  task automatic send(input int idx, input logic [7:0] d, input bit hold);
    @(negedge clk);
    start[idx] = 1'b1;
    data[idx]  = d;
    step();
    if (!hold) start[idx] = 1'b0;
  endtask

  // Checks every cycle of a frame from the accepting edge through one cycle past Done.
  task automatic check_frame(input int idx, input logic [11:0] exp_bits, input int nbits,
                             input int chg_at, input logic [7:0] chg_data, input bit pulse,
                             input bit expect_next);
    int len;
    logic [2:0] act, exp, rec_act, rec_exp;
    bit bad;
    len = nbits * T;
    for (int b = 0; b < nbits; b++) begin
      bad = 1'b0;
      rec_act = '0;
      rec_exp = '0;
      for (int c = 0; c < T; c++) begin
        int k;
        k = b * T + c;
        if (k == chg_at) begin
          data[idx] = chg_data;
          if (pulse) start[idx] = 1'b1;
        end
        if (pulse && k == chg_at + 1) start[idx] = 1'b0;
        act = {tx_w[idx], busy_w[idx], done_w[idx]};
        exp = {exp_bits[b], 1'b1, 1'b0};
        if (!bad) begin
          rec_act = act;
          rec_exp = exp;
          if (act !== exp) bad = 1'b1;
        end
        step();
      end
      chk($sformatf("dut%0d frame bit %0d", idx, b), rec_act, rec_exp);
    end
    chk($sformatf("dut%0d done edge", idx), {tx_w[idx], busy_w[idx], done_w[idx]}, 3'b101);
    step();
    chk($sformatf("dut%0d after done", idx), {tx_w[idx], busy_w[idx], done_w[idx]},
        {~expect_next, expect_next, 1'b0});
  endtask

  task automatic check_idle(input int idx, input int cycles, input string name);
    logic [2:0] rec;
    rec = 3'b100;
    for (int i = 0; i < cycles; i++) begin
      if (rec == 3'b100) rec = {tx_w[idx], busy_w[idx], done_w[idx]};
      step();
    end
    chk(name, rec, 3'b100);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    vecs[0] = '{dut: 0, data: 8'h55, nbits: 10, bits: 12'b0010_1010_1010};
    vecs[1] = '{dut: 1, data: 8'h07, nbits: 11, bits: 12'b0110_0000_1110};
    vecs[2] = '{dut: 2, data: 8'h00, nbits: 11, bits: 12'b0110_0000_0000};
    vecs[3] = '{dut: 1, data: 8'h00, nbits: 11, bits: 12'b0100_0000_0000};
    vecs[4] = '{dut: 3, data: 8'hA3, nbits: 11, bits: 12'b0111_0100_0110};
    vecs[5] = '{dut: 0, data: 8'hFF, nbits: 10, bits: 12'b0011_1111_1110};
    vecs[6] = '{dut: 2, data: 8'hA3, nbits: 11, bits: 12'b0111_0100_0110};

    #12;
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset dut%0d", i), {tx_w[i], busy_w[i], done_w[i]}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].dut, vecs[v].data, 1'b0);
      check_frame(vecs[v].dut, vecs[v].bits, vecs[v].nbits, -1, 8'h00, 1'b0, 1'b0);
    end

    // Start held high, Data changed mid-frame: back-to-back frames one idle clock apart.
    send(0, 8'h55, 1'b1);
    check_frame(0, 12'b0010_1010_1010, 10, 300, 8'h3C, 1'b0, 1'b1);
    start[0] = 1'b0;
    check_frame(0, 12'b0010_0111_1000, 10, -1, 8'h00, 1'b0, 1'b0);

    // Start pulsed while busy is ignored.
    send(0, 8'h55, 1'b0);
    check_frame(0, 12'b0010_1010_1010, 10, 200, 8'h00, 1'b1, 1'b0);
    check_idle(0, 100, "no second frame after busy start");

    // Reset during data bit 4 (frame bit 5) abandons the frame.
    send(0, 8'h00, 1'b0);
    for (int k = 0; k < 470; k++) step();
    chk("pre-reset mid bit 4", {tx_w[0], busy_w[0], done_w[0]}, 3'b010);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset mid-frame", {tx_w[0], busy_w[0], done_w[0]}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle(0, 20, "no done after reset");
    send(0, 8'hFF, 1'b0);
    check_frame(0, 12'b0011_1111_1110, 10, -1, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1 by default, with optional parity and a second stop bit. The peer of the team's existing UART receiver.
- Accepts one byte per Start_i handshake and serialises it LSB-first on Tx_o.
- Pulses Done_o when the frame completes.
- Sits between a byte producer (command/debug logic) and the board TX pin.

Parameters:
- CLOCK_HZ, 10_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. TICKS = CLOCK_HZ / BAUD (integer division) clocks per bit; must be >= 2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even. Any other value is treated as none.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start_i  input  1  request to send Data_i; sampled on an edge where Busy_o==0.
- Data_i  input  8  byte to send; latched on the accepting edge.
- Tx_o  output  1  serial line, idle high.
- Busy_o  output  1  high from the accepting edge until the end of the last stop bit.
- Done_o  output  1  single-cycle pulse at frame completion.

Behaviour:
- Reset (async, while Reset=1): Tx_o=1, Busy_o=0, Done_o=0, state IDLE, bit counter 0, tick counter 0, shift register 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Tx_o=1. On an edge with Start_i=1, latch Data_i into the shift register, go to START, set Busy_o=1, clear the tick counter. Tx_o=0 from that edge (zero-cycle latency from accept to start bit).
- Each non-IDLE state holds its Tx_o level for exactly TICKS clocks. The tick counter counts 0..TICKS-1; the state advances on the edge where the count equals TICKS-1, and the counter wraps to 0.
- START -> DATA.
- DATA: Tx_o = shift[0]. At the end of each bit period, shift right and increment the bit counter. After bit 7: go to PARITY if PARITY is 1 or 2, else to STOP.
- Parity bit = XOR of the 8 latched data bits, inverted for odd mode. Computed from the byte latched at accept, never from the live Data_i.
- PARITY -> STOP.
- STOP: Tx_o=1 for STOP_BITS*TICKS clocks. On the final edge: state IDLE, Busy_o=0, Done_o=1 for that one cycle.
- Frame length = (1+8+P+STOP_BITS)*TICKS clocks, where P=1 if parity is enabled.
- Start_i while Busy_o=1: ignored, no queueing. Data_i changes during the frame have no effect.
- Start_i held high continuously: the next frame is accepted on the edge after Done_o. This gives exactly 1 extra idle-high clock between frames.
- Done_o and a new accept never occur on the same edge.
- Reset asserted mid-frame: Tx_o returns to 1 immediately (async). No Done_o pulse. The partially sent frame is abandoned.
- Counters must be wide enough for TICKS-1 and for bit index 0..7. No counter overflows for any legal parameter set.

Decomposition:
- Package uart_pkg: FSM state encoding; PARITY_NONE/ODD/EVEN constants; the TICKS derivation as a constant function shared with the receiver.
- Sub-module uart_baud_counter: tick counter with enable and synchronous clear. Outputs a one-cycle strobe at count TICKS-1. Instantiated once, enabled while Busy_o=1 and cleared on accept.
- Shift register and FSM live in uart_tx.

Test Plan:
- Defaults (TICKS=86), Data_i=0x55, Start_i pulsed one cycle. Expect:
  - Tx_o sampled mid-bit = 0,1,0,1,0,1,0,1,0,1.
  - Each level lasts 86 clocks.
  - Done_o pulses exactly 860 clocks after the accept edge, coincident with Busy_o falling.
- PARITY=2, Data_i=0x07 -> parity bit 1, 11-bit frame, Done_o at 946 clocks. PARITY=1, Data_i=0x00 -> parity bit 1. PARITY=2, Data_i=0x00 -> parity bit 0.
- STOP_BITS=2, Data_i=0xA3 -> data bits 1,1,0,0,0,1,0,1, then Tx_o high for 172 clocks before Done_o; total frame 946 clocks.
- Start_i held high with Data_i changed to 0x3C mid-frame:
  - First frame still carries the original byte.
  - Second frame starts one clock after Done_o and carries 0x3C.
  - No Done_o pulse is missed or doubled.
- Reset asserted during data bit 4 -> Tx_o=1, Busy_o=0 in the same cycle, no Done_o. After release, a new frame with 0xFF transmits correctly from its start bit.
- Start_i pulsed while Busy_o=1 -> ignored. Exactly one frame and one Done_o result.
